// File: rtl/snax_cgra_pkg.sv
// Shared types and constants for the SNAX-side CGRA CSR arbiter.
//   csr_req_t     : registered CSR request payload {addr, data, write}
//   trk_entry_t   : outstanding-read tracker entry {req, id}; fields are sized
//                   for the largest supported NumReq / IdWidth and the arbiter
//                   uses only the low bits it needs.
//   CsrAddrOffsetDefault : base of the CGRA CSR window in the SNAX address map.
//   rebase_addr() : converts an absolute CSR address into a CGRA-local one.
package snax_cgra_pkg;

  localparam logic [31:0] CsrAddrOffsetDefault = 32'h0000_03c0;

  localparam int unsigned MaxReqIdxWidth = 8;
  localparam int unsigned MaxIdWidth     = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        write;
  } csr_req_t;

  typedef struct packed {
    logic [MaxReqIdxWidth-1:0] req;
    logic [MaxIdWidth-1:0]     id;
  } trk_entry_t;

  // Wraps modulo 2^32, so addresses below the offset alias high.
  function automatic logic [31:0] rebase_addr(input logic [31:0] addr,
                                              input logic [31:0] offset);
    return addr - offset;
  endfunction

endpackage

// File: rtl/snax_cgra_rr_arbiter.sv
// Combinational round-robin winner selection.
//   req_i       : eligible-requester vector
//   ptr_i       : round-robin pointer (first index searched)
//   gnt_valid_o : some requester is eligible
//   gnt_idx_o   : lowest eligible index at or after ptr_i, wrapping around
module snax_cgra_rr_arbiter #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic              gnt_valid_o,
  output logic [IdxW-1:0]   gnt_idx_o
);

  logic [IdxW-1:0] cand;

  // Walk the requesters starting at the pointer; the first hit wins.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    cand        = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = IdxW'((int'(ptr_i) + k) % NumReq);
      if (!gnt_valid_o && req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/snax_cgra_csr_arbiter.sv
// Shares one CGRA CSR port between NumReq SNAX-side requesters.
//   clk_i / rst_i          : clock, synchronous active-high reset
//   req_*                  : per-requester request channel (valid/ready)
//   rsp_*                  : read responses, valid routed to the issuing
//                            requester, data/id on a shared bus
//   csr_req_* / csr_rsp_*  : single CGRA CSR manager port
//   dbg_state_o            : FSM state (0 = IDLE, 1 = ISSUE)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Valid never waits on ready; once asserted, csr_req_* payload holds
// until the transfer. Only reads produce a CSR response.
module snax_cgra_csr_arbiter
  import snax_cgra_pkg::*;
#(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned IdWidth       = 5,
  parameter int unsigned Depth         = 4,
  parameter logic [31:0] CsrAddrOffset = CsrAddrOffsetDefault
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumReq-1:0]               req_valid_i,
  output logic [NumReq-1:0]               req_ready_o,
  input  logic [NumReq-1:0][31:0]         req_addr_i,
  input  logic [NumReq-1:0][31:0]         req_data_i,
  input  logic [NumReq-1:0]               req_write_i,
  input  logic [NumReq-1:0][IdWidth-1:0]  req_id_i,
  output logic [NumReq-1:0]               rsp_valid_o,
  input  logic [NumReq-1:0]               rsp_ready_i,
  output logic [31:0]                     rsp_data_o,
  output logic [IdWidth-1:0]              rsp_id_o,
  output logic                            csr_req_valid_o,
  output logic [31:0]                     csr_req_addr_o,
  output logic [31:0]                     csr_req_data_o,
  output logic                            csr_req_write_o,
  input  logic                            csr_req_ready_i,
  input  logic                            csr_rsp_valid_i,
  input  logic [31:0]                     csr_rsp_data_i,
  output logic                            csr_rsp_ready_o,
  output logic [0:0]                      dbg_state_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StIssue = 1'b1;

  // ---------------- state ----------------
  logic [0:0]                   state_q, state_d;
  logic [IdxW-1:0]              rr_q, rr_d;
  csr_req_t                     csr_q, csr_d;
  trk_entry_t [Depth-1:0]       mem_q, mem_d;
  logic [PtrW-1:0]              wptr_q, wptr_d;
  logic [PtrW-1:0]              rptr_q, rptr_d;
  logic [CntW-1:0]              count_q, count_d;

  // ---------------- arbitration ----------------
  logic                         trk_full;
  logic                         trk_empty;
  logic [NumReq-1:0]            elig;
  logic                         gnt_valid;
  logic [IdxW-1:0]              gnt_idx;
  logic                         can_accept;
  logic                         accept;
  logic                         push;
  logic                         pop;
  trk_entry_t                   head;
  logic [IdxW-1:0]              head_req;
  logic [$bits(trk_entry_t)-1:0] unused_head;

  // Fullness uses the registered count, so a read stalled by a full tracker
  // is still held in the cycle its slot is being freed.
  assign trk_full  = (count_q == CntW'(Depth));
  assign trk_empty = (count_q == '0);

  always_comb begin
    elig = '0;
    for (int i = 0; i < NumReq; i++) begin
      elig[i] = req_valid_i[i] & (req_write_i[i] | ~trk_full);
    end
  end

  snax_cgra_rr_arbiter #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_arbiter (
    .req_i       (elig),
    .ptr_i       (rr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // The output register can take a new request when empty, or when its
  // current content is leaving this cycle.
  assign can_accept  = (state_q == StIdle) | csr_req_ready_i;
  assign accept      = can_accept & gnt_valid;
  assign req_ready_o = accept ? (NumReq'(1) << gnt_idx) : '0;

  assign push = accept & ~req_write_i[gnt_idx];
  assign pop  = csr_rsp_valid_i & csr_rsp_ready_o;

  // ---------------- request path ----------------
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    csr_d   = csr_q;
    if (accept) begin
      state_d     = StIssue;
      csr_d.addr  = rebase_addr(req_addr_i[gnt_idx], CsrAddrOffset);
      csr_d.data  = req_data_i[gnt_idx];
      csr_d.write = req_write_i[gnt_idx];
      rr_d        = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
    end else if ((state_q == StIssue) && csr_req_ready_i) begin
      state_d = StIdle;
    end
  end

  assign csr_req_valid_o = (state_q == StIssue);
  assign csr_req_addr_o  = csr_q.addr;
  assign csr_req_data_o  = csr_q.data;
  assign csr_req_write_o = csr_q.write;
  assign dbg_state_o     = state_q;

  // ---------------- outstanding-read tracker ----------------
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wptr_q].req = MaxReqIdxWidth'(gnt_idx);
      mem_d[wptr_q].id  = MaxIdWidth'(req_id_i[gnt_idx]);
      wptr_d            = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // ---------------- response path ----------------
  assign head        = mem_q[rptr_q];
  assign head_req    = head.req[IdxW-1:0];
  assign unused_head = head;

  // A response with no outstanding read is never acknowledged or forwarded.
  assign rsp_valid_o     = (csr_rsp_valid_i & ~trk_empty) ? (NumReq'(1) << head_req) : '0;
  assign rsp_data_o      = csr_rsp_data_i;
  assign rsp_id_o        = head.id[IdWidth-1:0];
  assign csr_rsp_ready_o = ~trk_empty & rsp_ready_i[head_req];

  // ---------------- registers ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      rr_q    <= '0;
      csr_q   <= '0;
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      csr_q   <= csr_d;
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_snax_cgra_csr_arbiter.sv
// Bench for snax_cgra_csr_arbiter (NumReq=2, IdWidth=5, Depth=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. A monitor keeps a queue of expected CSR requests and a model
// of the outstanding-read order, and checks both as the DUT produces them.
module tb_snax_cgra_csr_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][31:0]  req_addr;
  logic [1:0][31:0]  req_data;
  logic [1:0]        req_write;
  logic [1:0][4:0]   req_id;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [31:0]       rsp_data;
  logic [4:0]        rsp_id;
  logic              csr_req_valid;
  logic [31:0]       csr_req_addr;
  logic [31:0]       csr_req_data;
  logic              csr_req_write;
  logic              csr_req_ready;
  logic              csr_rsp_valid;
  logic [31:0]       csr_rsp_data;
  logic              csr_rsp_ready;
  logic [0:0]        dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [64:0] exp_q[$];   // {addr, data, write} expected on the CSR port
  logic [5:0]  trk_q[$];   // {owner, id} of outstanding reads, oldest first

  snax_cgra_csr_arbiter dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_addr_i      (req_addr),
    .req_data_i      (req_data),
    .req_write_i     (req_write),
    .req_id_i        (req_id),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_data_o      (rsp_data),
    .rsp_id_o        (rsp_id),
    .csr_req_valid_o (csr_req_valid),
    .csr_req_addr_o  (csr_req_addr),
    .csr_req_data_o  (csr_req_data),
    .csr_req_write_o (csr_req_write),
    .csr_req_ready_i (csr_req_ready),
    .csr_rsp_valid_i (csr_rsp_valid),
    .csr_rsp_data_i  (csr_rsp_data),
    .csr_rsp_ready_o (csr_rsp_ready),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] id);
    req_valid[i] = v;
    req_write[i] = w;
    req_addr[i]  = a;
    req_data[i]  = d;
    req_id[i]    = id;
  endtask

  task automatic idle_reqs();
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_data  = '0;
    req_id    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_reqs();
    csr_rsp_valid = 1'b0;
    csr_rsp_data  = '0;
    to_pos();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_csr_valid"}, 96'(csr_req_valid), 96'd0);
    check({tag, "_csr_addr"},  96'(csr_req_addr),  96'd0);
    check({tag, "_csr_data"},  96'(csr_req_data),  96'd0);
    check({tag, "_csr_write"}, 96'(csr_req_write), 96'd0);
    check({tag, "_req_ready"}, 96'(req_ready),     96'd0);
    check({tag, "_rsp_valid"}, 96'(rsp_valid),     96'd0);
    check({tag, "_rsp_ready"}, 96'(csr_rsp_ready), 96'd0);
    check({tag, "_state"},     96'(dbg_state),     96'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [64:0] e_m;
  logic [5:0]  head_m;
  logic        exp_crdy;
  logic [1:0]  exp_rv;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      trk_q.delete();
    end else begin
      if (csr_req_valid && csr_req_ready) begin
        check("csr_req_expected", 96'(exp_q.size() != 0), 96'd1);
        if (exp_q.size() != 0) begin
          e_m = exp_q.pop_front();
          check("csr_req_payload", 96'({csr_req_addr, csr_req_data, csr_req_write}), 96'(e_m));
        end
      end
      head_m   = (trk_q.size() != 0) ? trk_q[0] : 6'd0;
      exp_crdy = (trk_q.size() != 0) && rsp_ready[head_m[5]];
      exp_rv   = ((trk_q.size() != 0) && csr_rsp_valid) ? (2'b01 << head_m[5]) : 2'b00;
      check("csr_rsp_ready", 96'(csr_rsp_ready), 96'(exp_crdy));
      check("rsp_valid",     96'(rsp_valid),     96'(exp_rv));
      if (csr_rsp_valid && exp_crdy) begin
        check("rsp_id",   96'(rsp_id),   96'(head_m[4:0]));
        check("rsp_data", 96'(rsp_data), 96'(csr_rsp_data));
        void'(trk_q.pop_front());
      end
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back({req_addr[i] - 32'h3c0, req_data[i], req_write[i]});
          if (!req_write[i]) trk_q.push_back({1'(i), req_id[i]});
        end
      end
    end
  end

  // ---------------- arbitration vectors (applied from reset, writes only) ----
  typedef struct packed {
    logic [1:0] valid;
    logic       ready;
    logic [1:0] exp_gnt;
    logic       exp_cvalid;
  } arb_vec_t;

  arb_vec_t vecs[13];

  // ---------------- test sequence ----------------
  logic [31:0] d0;

  initial begin
    vecs[0]  = '{2'b11, 1'b1, 2'b01, 1'b0};
    vecs[1]  = '{2'b11, 1'b1, 2'b10, 1'b1};
    vecs[2]  = '{2'b11, 1'b1, 2'b01, 1'b1};
    vecs[3]  = '{2'b11, 1'b1, 2'b10, 1'b1};
    vecs[4]  = '{2'b10, 1'b1, 2'b10, 1'b1};
    vecs[5]  = '{2'b10, 1'b1, 2'b10, 1'b1};
    vecs[6]  = '{2'b01, 1'b1, 2'b01, 1'b1};
    vecs[7]  = '{2'b01, 1'b0, 2'b00, 1'b1};
    vecs[8]  = '{2'b01, 1'b1, 2'b01, 1'b1};
    vecs[9]  = '{2'b00, 1'b1, 2'b00, 1'b1};
    vecs[10] = '{2'b00, 1'b0, 2'b00, 1'b0};
    vecs[11] = '{2'b11, 1'b0, 2'b10, 1'b0};
    vecs[12] = '{2'b00, 1'b1, 2'b00, 1'b1};

    rst = 1'b1;
    idle_reqs();
    rsp_ready     = 2'b11;
    csr_req_ready = 1'b0;
    csr_rsp_valid = 1'b0;
    csr_rsp_data  = '0;
    repeat (3) @(posedge clk);
    to_neg();
    check_all_zero("reset");
    to_pos();
    rst = 1'b0;

    // Single write: 0x3c4 -> 0x004, one cycle later.
    set_req(0, 1'b1, 1'b1, 32'h3c4, 32'hA5, 5'd0);
    to_neg();
    check("wr_req_ready", 96'(req_ready), 96'b01);
    check("wr_csr_valid_t0", 96'(csr_req_valid), 96'd0);
    to_pos();
    idle_reqs();
    to_neg();
    check("wr_csr_valid_t1", 96'(csr_req_valid), 96'd1);
    check("wr_csr_addr",  96'(csr_req_addr),  96'h004);
    check("wr_csr_data",  96'(csr_req_data),  96'hA5);
    check("wr_csr_write", 96'(csr_req_write), 96'd1);
    check("wr_no_rsp",    96'(rsp_valid),     96'd0);
    to_pos();
    csr_req_ready = 1'b1;
    to_neg();
    to_pos();

    // Round-robin / acceptance table.
    do_reset();
    for (int r = 0; r < 13; r++) begin
      for (int i = 0; i < 2; i++) begin
        set_req(i, vecs[r].valid[i], 1'b1, 32'h3c0 + 32'(r * 8 + i * 4), $urandom, 5'd0);
      end
      csr_req_ready = vecs[r].ready;
      to_neg();
      check($sformatf("arb_gnt_%0d", r),    96'(req_ready),     96'(vecs[r].exp_gnt));
      check($sformatf("arb_cvalid_%0d", r), 96'(csr_req_valid), 96'(vecs[r].exp_cvalid));
      to_pos();
    end
    idle_reqs();
    csr_req_ready = 1'b1;
    to_neg();
    to_pos();

    // Read routing: req1 id 7 then req0 id 3.
    do_reset();
    csr_req_ready = 1'b1;
    set_req(1, 1'b1, 1'b0, 32'h3c8, 32'd0, 5'd7);
    to_neg();
    check("rd_gnt1", 96'(req_ready), 96'b10);
    to_pos();
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    set_req(0, 1'b1, 1'b0, 32'h3d0, 32'd0, 5'd3);
    to_neg();
    check("rd_gnt0", 96'(req_ready), 96'b01);
    to_pos();
    idle_reqs();
    to_neg();
    to_pos();
    csr_rsp_valid = 1'b1;
    csr_rsp_data  = 32'h11;
    to_neg();
    check("rd_rsp1_valid", 96'(rsp_valid), 96'b10);
    check("rd_rsp1_data",  96'(rsp_data),  96'h11);
    check("rd_rsp1_id",    96'(rsp_id),    96'd7);
    to_pos();
    csr_rsp_data = 32'h22;
    to_neg();
    check("rd_rsp0_valid", 96'(rsp_valid), 96'b01);
    check("rd_rsp0_data",  96'(rsp_data),  96'h22);
    check("rd_rsp0_id",    96'(rsp_id),    96'd3);
    to_pos();
    csr_rsp_valid = 1'b0;

    // Tracker full: four reads fill it, writes still pass, fifth read waits.
    do_reset();
    csr_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, 1'b0, 32'h3c0 + 32'(k * 4), 32'd0, 5'(k));
      to_neg();
      check($sformatf("full_fill_%0d", k), 96'(req_ready), 96'b01);
      to_pos();
    end
    set_req(0, 1'b1, 1'b0, 32'h3f0, 32'd0, 5'd4);
    set_req(1, 1'b1, 1'b1, 32'h3e0, $urandom, 5'd0);
    to_neg();
    check("full_write_passes", 96'(req_ready), 96'b10);
    to_pos();
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    to_neg();
    check("full_read_held", 96'(req_ready), 96'b00);
    to_pos();
    csr_rsp_valid = 1'b1;
    csr_rsp_data  = $urandom;
    to_neg();
    check("full_held_at_pop", 96'(req_ready), 96'b00);
    check("full_pop_id", 96'(rsp_id), 96'd0);
    to_pos();
    csr_rsp_valid = 1'b0;
    to_neg();
    check("full_read_after_pop", 96'(req_ready), 96'b01);
    to_pos();
    idle_reqs();
    for (int k = 0; k < 4; k++) begin
      csr_rsp_valid = 1'b1;
      csr_rsp_data  = $urandom;
      to_neg();
      to_pos();
    end
    csr_rsp_valid = 1'b0;

    // Request backpressure: payload holds for three stalled cycles.
    do_reset();
    csr_req_ready = 1'b0;
    d0 = $urandom;
    set_req(0, 1'b1, 1'b1, 32'h400, d0, 5'd0);
    to_neg();
    check("bp_first_gnt", 96'(req_ready), 96'b01);
    to_pos();
    set_req(0, 1'b1, 1'b1, 32'h500, $urandom, 5'd0);
    set_req(1, 1'b1, 1'b1, 32'h600, $urandom, 5'd0);
    for (int k = 0; k < 3; k++) begin
      to_neg();
      check($sformatf("bp_gnt_%0d", k),   96'(req_ready),    96'b00);
      check($sformatf("bp_hold_%0d", k),  96'({csr_req_valid, csr_req_addr, csr_req_data, csr_req_write}),
            96'({1'b1, 32'h040, d0, 1'b1}));
      to_pos();
    end
    csr_req_ready = 1'b1;
    to_neg();
    check("bp_release_gnt", 96'(req_ready), 96'b10);
    to_pos();
    idle_reqs();
    to_neg();
    to_pos();

    // Response backpressure: owner not ready blocks the pop.
    set_req(1, 1'b1, 1'b0, 32'h3d0, 32'd0, 5'd9);
    to_neg();
    check("rbp_gnt", 96'(req_ready), 96'b10);
    to_pos();
    idle_reqs();
    csr_rsp_valid = 1'b1;
    csr_rsp_data  = 32'h33;
    rsp_ready     = 2'b01;
    for (int k = 0; k < 2; k++) begin
      to_neg();
      check($sformatf("rbp_crdy_%0d", k), 96'(csr_rsp_ready), 96'd0);
      check($sformatf("rbp_valid_%0d", k), 96'(rsp_valid), 96'b10);
      to_pos();
    end
    rsp_ready = 2'b11;
    to_neg();
    check("rbp_crdy_release", 96'(csr_rsp_ready), 96'd1);
    check("rbp_id", 96'(rsp_id), 96'd9);
    to_pos();
    csr_rsp_valid = 1'b0;

    // Reset with two reads outstanding and a stalled write, then a stray response.
    do_reset();
    csr_req_ready = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h3c0, 32'd0, 5'd1);
    to_neg();
    to_pos();
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    set_req(1, 1'b1, 1'b0, 32'h3c4, 32'd0, 5'd2);
    to_neg();
    to_pos();
    set_req(1, 1'b1, 1'b1, 32'h3e0, $urandom, 5'd0);
    to_neg();
    check("mid_write_gnt", 96'(req_ready), 96'b10);
    to_pos();
    idle_reqs();
    csr_req_ready = 1'b0;
    to_neg();
    check("mid_issue_pending", 96'(csr_req_valid), 96'd1);
    to_pos();
    rst = 1'b1;
    to_neg();
    to_pos();
    rst = 1'b0;
    to_neg();
    check_all_zero("midrst");
    to_pos();
    csr_rsp_valid = 1'b1;
    csr_rsp_data  = 32'hdead;
    to_neg();
    check("spur_crdy",  96'(csr_rsp_ready), 96'd0);
    check("spur_valid", 96'(rsp_valid),     96'd0);
    to_pos();
    csr_rsp_valid = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h3c0, 32'd0, 5'h15);
    to_neg();
    to_pos();
    idle_reqs();
    csr_req_ready = 1'b1;
    csr_rsp_valid = 1'b1;
    csr_rsp_data  = 32'h77;
    to_neg();
    check("post_rst_valid", 96'(rsp_valid), 96'b01);
    check("post_rst_id",    96'(rsp_id),    96'h15);
    to_pos();
    csr_rsp_valid = 1'b0;
    repeat (2) begin
      to_neg();
      to_pos();
    end

    check("end_csr_queue_empty", 96'(exp_q.size()), 96'd0);
    check("end_trk_queue_empty", 96'(trk_q.size()), 96'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
